// File: rtl/hp_pkg.sv
// hp_pkg: shared types, widths and helper arithmetic for the hit-point
// controller and its per-ship pending-hit counter.
//   HP_W        width of a hit-point value / bar width in pixels
//   PEND_W      width of the pending-hit counter (saturates at all ones)
//   DMG_W       width of the per-frame damage product
//   hp_state_t  IDLE / PLAY / APPLY / OVER
//   W_*         winner codes reported to the game FSM
package hp_pkg;

  localparam int HP_W   = 10;
  localparam int PEND_W = 4;
  localparam int DMG_W  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    APPLY = 2'd2,
    OVER  = 2'd3
  } hp_state_t;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_SHIP1 = 2'b01;
  localparam logic [1:0] W_SHIP2 = 2'b10;
  localparam logic [1:0] W_DRAW  = 2'b11;

  // Remove pend*dmg_per_hit from hp, clamping at zero. The product is
  // formed at full width so 15 hits never wrap before the compare.
  function automatic logic [HP_W-1:0] apply_damage(
    input logic [HP_W-1:0]   hp,
    input logic [PEND_W-1:0] pend,
    input logic [HP_W-1:0]   dmg_per_hit
  );
    logic [DMG_W-1:0] dmg;
    dmg = {{(DMG_W-PEND_W){1'b0}}, pend} * {{(DMG_W-HP_W){1'b0}}, dmg_per_hit};
    if (dmg >= {{(DMG_W-HP_W){1'b0}}, hp}) begin
      return '0;
    end
    return hp - dmg[HP_W-1:0];
  endfunction

  // Add one regen step, saturating at hp_max. A destroyed ship (hp==0)
  // is never brought back.
  function automatic logic [HP_W-1:0] regen_step(
    input logic [HP_W-1:0] hp,
    input logic [HP_W-1:0] amt,
    input logic [HP_W-1:0] hp_max
  );
    logic [HP_W:0] sum;
    if (hp == '0) begin
      return '0;
    end
    sum = {1'b0, hp} + {1'b0, amt};
    if (sum > {1'b0, hp_max}) begin
      return hp_max;
    end
    return sum[HP_W-1:0];
  endfunction

endpackage

// File: rtl/hp_hit_accum.sv
// hp_hit_accum: per-ship saturating counter of hits recorded since the
// last frame was applied.
//   Clk       system clock
//   Reset     asynchronous, active-high reset (count -> 0)
//   inc       +1, holding at the maximum instead of wrapping
//   clr       reload the counter; has priority over inc
//   clr_load  value of bit 0 on reload, so a hit arriving in the same
//             cycle as the clear is carried into the next frame
//   count     current pending-hit count
module hp_hit_accum
  import hp_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              inc,
  input  logic              clr,
  input  logic              clr_load,
  output logic [PEND_W-1:0] count
);

  // Pending-hit register: clear/reload wins over increment, and the
  // increment stops once every bit is set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= {{(PEND_W-1){1'b0}}, clr_load};
    end else if (inc && (count != {PEND_W{1'b1}})) begin
      count <= count + PEND_W'(1);
    end
  end

endmodule

// File: rtl/hp_controller.sv
// hp_controller: owns both ships' hit points (the HP bar widths). Hits
// are gathered during a frame and applied in a single APPLY cycle after
// the frame strobe rises, so bars never change mid-scan. Detects the end
// of a round and reports the winner.
//   Clk        system clock
//   Reset      asynchronous, active-high reset
//   frame_clk  Clk-synchronous frame level; a rising edge starts a frame
//   start      1-cycle pulse: begin or restart a round (any state)
//   hit1/hit2  1-cycle pulses: ship 1 / ship 2 was hit
//   ship1_hp   ship 1 hit points / bar width
//   ship2_hp   ship 2 hit points / bar width
//   playing    high in PLAY and APPLY
//   game_over  high in OVER
//   winner     00 none, 01 ship1, 10 ship2, 11 draw
module hp_controller
  import hp_pkg::*;
#(
  parameter logic [HP_W-1:0] HP_MAX       = 10'd200,
  parameter logic [HP_W-1:0] HIT_DMG      = 10'd20,
  parameter logic [7:0]      REGEN_PERIOD = 8'd60,
  parameter logic [HP_W-1:0] REGEN_AMT    = 10'd1,
  parameter logic [7:0]      OVER_HOLD    = 8'd120
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic            start,
  input  logic            hit1,
  input  logic            hit2,
  output logic [HP_W-1:0] ship1_hp,
  output logic [HP_W-1:0] ship2_hp,
  output logic            playing,
  output logic            game_over,
  output logic [1:0]      winner
);

  hp_state_t         state, state_nxt;
  logic              frame_q;
  logic              fe;
  logic [PEND_W-1:0] pend1, pend2;
  logic [HP_W-1:0]   hp1, hp2, hp1_nxt, hp2_nxt;
  logic [HP_W-1:0]   hp1_dmg, hp2_dmg, hp1_new, hp2_new;
  logic [1:0]        winner_q, winner_nxt;
  logic [7:0]        regen_cnt, regen_nxt;
  logic [7:0]        hold_cnt, hold_nxt;
  logic              regen_due;
  logic              in_apply;
  logic              acc_inc1, acc_inc2, acc_clr, acc_load1, acc_load2;

  assign fe       = frame_clk & ~frame_q;
  assign in_apply = (state == APPLY);

  // Hits only count while the round is live in PLAY. Leaving APPLY (or a
  // restart) clears the counters; a hit landing in the APPLY cycle itself
  // reloads a 1 so it is charged on the next frame instead of dropped.
  assign acc_inc1  = (state == PLAY) & hit1 & ~start;
  assign acc_inc2  = (state == PLAY) & hit2 & ~start;
  assign acc_clr   = start | in_apply;
  assign acc_load1 = in_apply & hit1 & ~start;
  assign acc_load2 = in_apply & hit2 & ~start;

  hp_hit_accum u_accum1 (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (acc_inc1),
    .clr      (acc_clr),
    .clr_load (acc_load1),
    .count    (pend1)
  );

  hp_hit_accum u_accum2 (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (acc_inc2),
    .clr      (acc_clr),
    .clr_load (acc_load2),
    .count    (pend2)
  );

  // Per-frame arithmetic: damage first, then an optional regen step on
  // the survivors. regen_cnt counts APPLY cycles; a period of 0 disables
  // regen entirely.
  always_comb begin
    hp1_dmg   = apply_damage(hp1, pend1, HIT_DMG);
    hp2_dmg   = apply_damage(hp2, pend2, HIT_DMG);
    regen_due = (REGEN_PERIOD != 8'd0) && (regen_cnt == (REGEN_PERIOD - 8'd1));
    hp1_new   = hp1_dmg;
    hp2_new   = hp2_dmg;
    if (regen_due) begin
      hp1_new = regen_step(hp1_dmg, REGEN_AMT, HP_MAX);
      hp2_new = regen_step(hp2_dmg, REGEN_AMT, HP_MAX);
    end
  end

  // Next-state and next-datapath logic. start outranks everything,
  // including a coincident frame edge, so a restart always lands in PLAY
  // with full bars.
  always_comb begin
    state_nxt  = state;
    hp1_nxt    = hp1;
    hp2_nxt    = hp2;
    winner_nxt = winner_q;
    regen_nxt  = regen_cnt;
    hold_nxt   = hold_cnt;
    if (start) begin
      state_nxt  = PLAY;
      hp1_nxt    = HP_MAX;
      hp2_nxt    = HP_MAX;
      winner_nxt = W_NONE;
      regen_nxt  = '0;
      hold_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        PLAY: begin
          if (fe) begin
            state_nxt = APPLY;
          end
        end
        APPLY: begin
          hp1_nxt   = hp1_new;
          hp2_nxt   = hp2_new;
          regen_nxt = regen_due ? 8'd0 : regen_cnt + 8'd1;
          hold_nxt  = '0;
          if ((hp1_new == '0) && (hp2_new == '0)) begin
            winner_nxt = W_DRAW;
            state_nxt  = OVER;
          end else if (hp2_new == '0) begin
            winner_nxt = W_SHIP1;
            state_nxt  = OVER;
          end else if (hp1_new == '0) begin
            winner_nxt = W_SHIP2;
            state_nxt  = OVER;
          end else begin
            state_nxt = PLAY;
          end
        end
        OVER: begin
          // The OVER_HOLD-th frame edge seen in OVER returns to IDLE.
          if (fe) begin
            if (({1'b0, hold_cnt} + 9'd1) >= {1'b0, OVER_HOLD}) begin
              state_nxt = IDLE;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: bars, winner, frame/hold counters and the
  // frame-strobe delay used for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hp1       <= '0;
      hp2       <= '0;
      winner_q  <= W_NONE;
      regen_cnt <= '0;
      hold_cnt  <= '0;
      frame_q   <= 1'b0;
    end else begin
      hp1       <= hp1_nxt;
      hp2       <= hp2_nxt;
      winner_q  <= winner_nxt;
      regen_cnt <= regen_nxt;
      hold_cnt  <= hold_nxt;
      frame_q   <= frame_clk;
    end
  end

  assign ship1_hp  = hp1;
  assign ship2_hp  = hp2;
  assign winner    = winner_q;
  assign playing   = (state == PLAY) || (state == APPLY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_hp_controller.sv
// tb_hp_controller: directed checks of hp_controller. u_dut uses the
// default parameters; u_dut_b runs with REGEN_PERIOD=2, HIT_DMG=10 and
// OVER_HOLD=3 to reach regen and the OVER hold in a few frames.
module tb_hp_controller;

  logic       Clk;
  logic       Reset;
  logic       frame_clk, start, hit1, hit2;
  logic [9:0] ship1_hp, ship2_hp;
  logic       playing, game_over;
  logic [1:0] winner;

  logic       frame_clk_b, start_b, hit1_b, hit2_b;
  logic [9:0] ship1_hp_b, ship2_hp_b;
  logic       playing_b, game_over_b;
  logic [1:0] winner_b;

  int passes = 0;
  int total  = 0;

  hp_controller u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .start     (start),
    .hit1      (hit1),
    .hit2      (hit2),
    .ship1_hp  (ship1_hp),
    .ship2_hp  (ship2_hp),
    .playing   (playing),
    .game_over (game_over),
    .winner    (winner)
  );

  hp_controller #(
    .HP_MAX       (10'd200),
    .HIT_DMG      (10'd10),
    .REGEN_PERIOD (8'd2),
    .REGEN_AMT    (10'd1),
    .OVER_HOLD    (8'd3)
  ) u_dut_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk_b),
    .start     (start_b),
    .hit1      (hit1_b),
    .hit2      (hit2_b),
    .ship1_hp  (ship1_hp_b),
    .ship2_hp  (ship2_hp_b),
    .playing   (playing_b),
    .game_over (game_over_b),
    .winner    (winner_b)
  );

  // Free-running system clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One frame on u_dut: low cycle, rising edge (-> APPLY), APPLY cycle.
  task automatic frame_a();
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic frame_b();
    frame_clk_b = 1'b0;
    tick();
    frame_clk_b = 1'b1;
    tick();
    frame_clk_b = 1'b0;
    tick();
  endtask

  task automatic start_a();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive both hit lines for n consecutive cycles (one pulse per cycle).
  task automatic hits_a(input int n, input logic h1, input logic h2);
    for (int i = 0; i < n; i++) begin
      hit1 = h1;
      hit2 = h2;
      tick();
    end
    hit1 = 1'b0;
    hit2 = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0; start = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    frame_clk_b = 1'b0; start_b = 1'b0; hit1_b = 1'b0; hit2_b = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    $display("[TB] reset state");
    check("rst_hp1", ship1_hp, 10'd0);
    check("rst_hp2", ship2_hp, 10'd0);
    check("rst_playing", {9'd0, playing}, 10'd0);
    check("rst_game_over", {9'd0, game_over}, 10'd0);
    check("rst_winner", {8'd0, winner}, 10'd0);

    $display("[TB] three hits on ship 1, one frame");
    start_a();
    check("start_hp1", ship1_hp, 10'd200);
    check("start_playing", {9'd0, playing}, 10'd1);
    hits_a(3, 1'b1, 1'b0);
    check("prefame_hp1", ship1_hp, 10'd200);
    frame_a();
    check("frame_hp1", ship1_hp, 10'd140);
    check("frame_hp2", ship2_hp, 10'd200);
    frame_a();
    check("pend_cleared_hp1", ship1_hp, 10'd140);

    $display("[TB] async reset mid-round");
    Reset = 1'b1;
    #1;
    check("async_hp1", ship1_hp, 10'd0);
    check("async_hp2", ship2_hp, 10'd0);
    check("async_playing", {9'd0, playing}, 10'd0);
    #1;
    Reset = 1'b0;
    tick();

    $display("[TB] saturating hits kill ship 2");
    start_a();
    hits_a(20, 1'b0, 1'b1);
    frame_a();
    check("kill_hp2", ship2_hp, 10'd0);
    check("kill_hp1", ship1_hp, 10'd200);
    check("kill_game_over", {9'd0, game_over}, 10'd1);
    check("kill_winner", {8'd0, winner}, 10'd1);
    check("kill_playing", {9'd0, playing}, 10'd0);

    $display("[TB] simultaneous final hits -> draw");
    start_a();
    check("restart_winner", {8'd0, winner}, 10'd0);
    hits_a(9, 1'b1, 1'b1);
    frame_a();
    check("draw_pre_hp1", ship1_hp, 10'd20);
    check("draw_pre_hp2", ship2_hp, 10'd20);
    check("draw_pre_playing", {9'd0, playing}, 10'd1);
    hits_a(1, 1'b1, 1'b1);
    frame_a();
    check("draw_hp1", ship1_hp, 10'd0);
    check("draw_hp2", ship2_hp, 10'd0);
    check("draw_winner", {8'd0, winner}, 10'd3);
    check("draw_game_over", {9'd0, game_over}, 10'd1);

    $display("[TB] hit during APPLY is deferred");
    start_a();
    frame_clk = 1'b1;
    tick();
    hit1 = 1'b1;
    tick();
    hit1 = 1'b0;
    frame_clk = 1'b0;
    check("apply_hit_not_now", ship1_hp, 10'd200);
    frame_a();
    check("apply_hit_next", ship1_hp, 10'd180);

    $display("[TB] start beats a coincident frame edge");
    hits_a(1, 1'b1, 1'b0);
    start = 1'b1;
    frame_clk = 1'b1;
    tick();
    start = 1'b0;
    frame_clk = 1'b0;
    check("prio_hp1", ship1_hp, 10'd200);
    check("prio_playing", {9'd0, playing}, 10'd1);
    frame_a();
    check("prio_pend_cleared", ship1_hp, 10'd200);

    $display("[TB] regen, saturation at max, OVER hold");
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hit1_b = 1'b1;
      tick();
    end
    hit1_b = 1'b0;
    frame_b();
    check("regen_f1_hp1", ship1_hp_b, 10'd150);
    frame_b();
    check("regen_f2_hp1", ship1_hp_b, 10'd151);
    check("regen_f2_hp2", ship2_hp_b, 10'd200);
    frame_b();
    check("regen_f3_hp1", ship1_hp_b, 10'd151);
    frame_b();
    check("regen_f4_hp1", ship1_hp_b, 10'd152);
    check("regen_f4_hp2", ship2_hp_b, 10'd200);
    for (int i = 0; i < 15; i++) begin
      hit1_b = 1'b1;
      tick();
    end
    hit1_b = 1'b0;
    frame_b();
    check("low_hp1", ship1_hp_b, 10'd2);
    hit1_b = 1'b1;
    tick();
    hit1_b = 1'b0;
    frame_b();
    check("no_revive_hp1", ship1_hp_b, 10'd0);
    check("b_winner", {8'd0, winner_b}, 10'd2);
    check("b_game_over", {9'd0, game_over_b}, 10'd1);
    frame_b();
    frame_b();
    check("hold2_game_over", {9'd0, game_over_b}, 10'd1);
    frame_b();
    check("hold3_game_over", {9'd0, game_over_b}, 10'd0);
    check("hold3_playing", {9'd0, playing_b}, 10'd0);
    check("hold3_winner", {8'd0, winner_b}, 10'd2);
    check("hold3_hp2", ship2_hp_b, 10'd200);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
